apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB4 requester: the initiating end of the APB_SLAVE bus.
- Accepts one command at a time on a valid/ready request port and runs the APB SETUP and ACCESS phases on the bus.
- Absorbs pready wait states and enforces a wait-state timeout.
- Returns read data and error status on a valid/ready response port.
- Sits between a CPU/DMA-side command source and one or more APB slaves; slave selection is external.

Parameters:
ADDR_WIDTH, 32, width of paddr and cmd_addr
DATA_WIDTH, 32, width of pwdata/prdata; must be 8, 16 or 32
DATA_STRB, DATA_WIDTH/8, byte-strobe width
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
nrst  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_STRB  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
rsp_err  out  1  slverr captured, or timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_STRB  APB strobes; forced 0 on reads
prot  out  3  APB protection
pready  in  1  slave ready
slverr  in  1  slave error, valid when psel && penable && pready
prdata  in  DATA_WIDTH  slave read data, valid under the same condition

Behaviour:
- Reset (asynchronous, nrst low):
  - All outputs 0; state IDLE.
  - Reset mid-transfer drops psel/penable immediately and discards the command and any pending response.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr/wdata/strb/prot/write into the bus registers and go to SETUP.
  - pstrb = cmd_strb on writes, 0 on reads.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, cmd_ready=0.
  - Go to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr/pwrite/pwdata/pstrb/prot held stable for the whole state.
  - Each cycle with pready=1: capture rsp_err=slverr; capture rsp_rdata=prdata on reads, 0 on writes; drop psel/penable; go to RESP.
  - Wait counter increments on each ACCESS cycle with pready=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with pready still 0: drop psel/penable, rsp_err=1, rsp_rdata=0, go to RESP.
  - A late pready after abort is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_ready: rsp_valid=0, go to IDLE.
  - Bus idle throughout (psel=0).
- Latency:
  - Accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2.
  - With zero wait states, rsp_valid is high in cycle N+3.
  - Minimum command-to-command spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP).
- APB4 rules held:
  - penable is never high without psel.
  - psel never drops between SETUP and the completing ACCESS cycle.
  - No back-to-back ACCESS without an intervening SETUP.
- Wait counter is wide enough to hold TIMEOUT; it clears on entry to SETUP.
- cmd inputs are ignored outside IDLE.
- rsp_ready is ignored when rsp_valid=0.

Test Plan:
- Write, no waits: cmd write addr=0x2, wdata=0x1004, strb=0xF, prot=3'b001; pready=1 -> SETUP cycle (psel=1, penable=0, paddr=0x2); ACCESS next cycle (penable=1, pwdata=0x1004); rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: read addr=0x2, strb input 0xF; pready low 3 ACCESS cycles, then high with prdata=0x1004 -> pstrb=0; paddr stable across all 4 ACCESS cycles; rsp_rdata=0x1004, rsp_err=0.
- Slave error: write with slverr=1 alongside pready -> rsp_err=1; next command still accepted normally.
- Timeout: TIMEOUT=4, pready held 0 -> psel/penable drop after 4 ACCESS cycles; rsp_err=1, rsp_rdata=0; pready pulsed afterwards has no effect.
- Response backpressure: rsp_ready low 5 cycles -> rsp_valid/rsp_rdata held stable; cmd_ready stays 0; command held on cmd_valid accepted one cycle after rsp_ready.
- Reset mid-ACCESS: nrst low during ACCESS -> psel, penable, rsp_valid and cmd_ready at 0 immediately; after release, IDLE with cmd_ready=1.

Source files
------------

// File: rtl/apb_master.sv
// APB4 requester: takes one command at a time, runs SETUP/ACCESS on the bus,
// absorbs wait states with an optional timeout, and returns a registered response.
//   state  | meaning
//   IDLE   | ready for a command, bus idle
//   SETUP  | psel high, penable low, one cycle
//   ACCESS | psel and penable high until pready or timeout
//   RESP   | response held until consumed
module apb_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_STRB  = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [DATA_STRB-1:0]  cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_STRB-1:0]  pstrb,
    output logic [2:0]            prot,
    input  logic                  pready,
    input  logic                  slverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         wait_cnt, wait_cnt_nxt, wait_inc;
    logic                  cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt, pwdata_nxt;
    logic                  psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [DATA_STRB-1:0]  pstrb_nxt;
    logic [2:0]            prot_nxt;

    assign wait_inc = wait_cnt + CW'(1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            prot      <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            psel      <= psel_nxt;
            penable   <= penable_nxt;
            pwrite    <= pwrite_nxt;
            paddr     <= paddr_nxt;
            pwdata    <= pwdata_nxt;
            pstrb     <= pstrb_nxt;
            prot      <= prot_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        psel_nxt      = psel;
        penable_nxt   = penable;
        pwrite_nxt    = pwrite;
        paddr_nxt     = paddr;
        pwdata_nxt    = pwdata;
        pstrb_nxt     = pstrb;
        prot_nxt      = prot;

        case (state)
            IDLE: begin
                // cmd_ready comes up one cycle after reset release
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_nxt = 1'b0;
                    psel_nxt      = 1'b1;
                    penable_nxt   = 1'b0;
                    pwrite_nxt    = cmd_write;
                    paddr_nxt     = cmd_addr;
                    pwdata_nxt    = cmd_wdata;
                    pstrb_nxt     = cmd_write ? cmd_strb : '0;
                    prot_nxt      = cmd_prot;
                    wait_cnt_nxt  = '0;
                    state_nxt     = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = slverr;
                    rsp_rdata_nxt = pwrite ? '0 : prdata;
                    state_nxt     = RESP;
                end else if (TIMEOUT != 0 && wait_inc == TIMEOUT_CNT) begin
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    state_nxt     = RESP;
                end else begin
                    wait_cnt_nxt = wait_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction timeline model drives the bus slave side
// and checks every output on each falling edge.
module tb_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 0, cmd_write = 0, rsp_ready = 0, pready = 0, slverr = 0;
    logic [AW-1:0] cmd_addr = 0;
    logic [DW-1:0] cmd_wdata = 0, prdata = 0;
    logic [SW-1:0] cmd_strb = 0;
    logic [2:0]    cmd_prot = 0;
    logic          cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
    logic [DW-1:0] rsp_rdata, pwdata;
    logic [AW-1:0] paddr;
    logic [SW-1:0] pstrb;
    logic [2:0]    prot;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_STRB(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .prot(prot), .pready(pready), .slverr(slverr), .prdata(prdata)
    );

    int checks = 0;
    int errors = 0;

    // expected outputs for the current cycle
    logic          exp_cmd_ready = 0, exp_psel = 0, exp_penable = 0, exp_rsp_valid = 0;
    logic          exp_rsp_err = 0, exp_pwrite = 0;
    logic [DW-1:0] exp_rsp_rdata = 0, exp_pwdata = 0;
    logic [AW-1:0] exp_paddr = 0;
    logic [SW-1:0] exp_pstrb = 0;
    logic [2:0]    exp_prot = 0;

    int cyc, obs_lat, obs_acc;
    logic [DW-1:0] obs_rdata;
    logic obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
        chk("psel", 32'(psel), 32'(exp_psel));
        chk("penable", 32'(penable), 32'(exp_penable));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
        if (exp_psel) begin
            chk("paddr", paddr, exp_paddr);
            chk("pwrite", 32'(pwrite), 32'(exp_pwrite));
            chk("pwdata", pwdata, exp_pwdata);
            chk("pstrb", 32'(pstrb), 32'(exp_pstrb));
            chk("prot", 32'(prot), 32'(exp_prot));
        end
        if (exp_rsp_valid) begin
            chk("rsp_rdata", rsp_rdata, exp_rsp_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(exp_rsp_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_valid && obs_lat < 0) begin
            obs_lat   = cyc;
            obs_rdata = rsp_rdata;
            obs_err   = rsp_err;
        end
        if (penable) obs_acc++;
    endtask

    task automatic junk_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input logic [2:0] pr, input int w,
                           input logic se, input logic [DW-1:0] rd, input int dly,
                           input int idle, input int rst_at);
        int n;
        logic timed_out;
        for (int i = 0; i < idle; i++) begin
            cmd_valid = 0; junk_cmd();
            rsp_ready = 1'($urandom); pready = 1'($urandom);
            exp_cmd_ready = 1; exp_psel = 0; exp_penable = 0; exp_rsp_valid = 0;
            step();
        end
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        cmd_strb = strb; cmd_prot = pr; rsp_ready = 1'($urandom);
        exp_cmd_ready = 1; exp_psel = 0; exp_penable = 0; exp_rsp_valid = 0;
        cyc = 0; obs_lat = -1; obs_acc = 0;
        step();
        // setup cycle: new command inputs must be ignored
        cmd_valid = 1'($urandom); junk_cmd();
        pready = 1'($urandom); slverr = 1'($urandom); prdata = $urandom;
        exp_cmd_ready = 0; exp_psel = 1; exp_penable = 0;
        exp_paddr = addr; exp_pwrite = wr; exp_pwdata = wdata;
        exp_pstrb = wr ? strb : '0; exp_prot = pr;
        step();
        timed_out = (w >= TO);
        n = timed_out ? TO : w + 1;
        for (int j = 0; j < n; j++) begin
            exp_penable = 1;
            pready = (j == w);
            slverr = (j == w) ? se : 1'($urandom);
            prdata = (j == w) ? rd : $urandom;
            cmd_valid = 1'($urandom); junk_cmd();
            if (j == rst_at) begin
                pready = 0;
                nrst = 0;
                exp_cmd_ready = 0; exp_psel = 0; exp_penable = 0; exp_rsp_valid = 0;
                #1;
                chk("rst_psel", 32'(psel), 32'd0);
                chk("rst_penable", 32'(penable), 32'd0);
                chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
                step();
                #2 nrst = 1;
                cmd_valid = 0;
                step();
                exp_cmd_ready = 1;
                return;
            end
            step();
        end
        exp_rsp_err   = timed_out ? 1'b1 : se;
        exp_rsp_rdata = (timed_out || wr) ? '0 : rd;
        exp_psel = 0; exp_penable = 0; exp_rsp_valid = 1;
        for (int k = 0; k <= dly; k++) begin
            pready = 1; slverr = 1'($urandom); prdata = $urandom;
            rsp_ready = (k == dly);
            cmd_valid = 1; junk_cmd();
            step();
        end
        cmd_valid = 0;
        exp_rsp_valid = 0; exp_cmd_ready = 1;
    endtask

    initial begin
        int w, nacc;
        nrst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_psel", 32'(psel), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_paddr", paddr, 32'd0);
        #3 nrst = 1;
        step();
        exp_cmd_ready = 1;

        run_txn(1, 32'h2, 32'h1004, 4'hF, 3'b001, 0, 0, 32'h0, 0, 1, -1);
        chk("wr_lat", 32'(obs_lat), 32'd3);
        chk("wr_err", 32'(obs_err), 32'd0);
        chk("wr_rdata", obs_rdata, 32'h0);
        chk("wr_acc", 32'(obs_acc), 32'd1);

        run_txn(0, 32'h2, 32'hDEAD, 4'hF, 3'b000, 3, 0, 32'h1004, 0, 1, -1);
        chk("rd_lat", 32'(obs_lat), 32'd6);
        chk("rd_rdata", obs_rdata, 32'h1004);
        chk("rd_acc", 32'(obs_acc), 32'd4);

        run_txn(1, 32'h8, 32'h55, 4'h3, 3'b010, 1, 1, 32'h0, 0, 0, -1);
        chk("slverr_err", 32'(obs_err), 32'd1);
        run_txn(1, 32'hC, 32'h77, 4'h1, 3'b000, 0, 0, 32'h0, 0, 0, -1);
        chk("after_err_lat", 32'(obs_lat), 32'd3);
        chk("after_err_err", 32'(obs_err), 32'd0);

        run_txn(0, 32'h10, 32'h0, 4'hF, 3'b000, 100, 0, 32'hFFFF, 2, 0, -1);
        chk("to_lat", 32'(obs_lat), 32'd6);
        chk("to_err", 32'(obs_err), 32'd1);
        chk("to_rdata", obs_rdata, 32'h0);
        chk("to_acc", 32'(obs_acc), 32'd4);

        run_txn(0, 32'h20, 32'h0, 4'h0, 3'b000, 1, 0, 32'hA5A5, 5, 0, -1);
        chk("bp_rdata", obs_rdata, 32'hA5A5);
        run_txn(1, 32'h24, 32'h1, 4'h1, 3'b000, 0, 0, 32'h0, 0, 0, -1);
        chk("bp_next_lat", 32'(obs_lat), 32'd3);

        run_txn(1, 32'h30, 32'h3, 4'hF, 3'b000, 5, 0, 32'h0, 0, 0, 1);
        run_txn(0, 32'h34, 32'h0, 4'hF, 3'b000, 0, 0, 32'h4321, 0, 1, -1);
        chk("post_rst_rdata", obs_rdata, 32'h4321);

        for (int t = 0; t < 150; t++) begin
            w = $urandom_range(0, 6);
            nacc = (w >= TO) ? TO : w + 1;
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom), w,
                    1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 19) == 0) ? $urandom_range(0, nacc - 1) : -1);
        end
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
